// File: rtl/imem_resp_pkg.sv
// Shared definitions for the instruction-memory responder: CPU width, FSM
// encoding, NOP constant, latency counter width and word-offset helper.
package imem_resp_pkg;

   localparam int CPU_WIDTH = 32;
   localparam int CNT_W     = 4;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Word distance between two word-aligned addresses (byte bits already dropped).
   function automatic logic [CPU_WIDTH-3:0] word_off(input logic [CPU_WIDTH-3:0] addr_w,
                                                     input logic [CPU_WIDTH-3:0] base_w);
      return addr_w - base_w;
   endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port and one
// registered read port; a same-edge write to the read word returns old data.
module imem_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wen,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          ren,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wen) mem[waddr] <= wdata;
      if (ren) rdata <= mem[raddr];
   end

endmodule

// File: rtl/imem_resp.sv
// Instruction fetch responder: IDLE/WAIT/RESP handshake with fixed LATENCY,
// range-checked reads and a loader write port. Optional IMEM_MISALIGN_CHK_EN
// flags fetches whose byte address is not word aligned.
module imem_resp
   import imem_resp_pkg::*;
#(
   parameter int                   DEPTH     = 1024,
   parameter int                   LATENCY   = 2,
   parameter logic [CPU_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [CPU_WIDTH-1:0] req_pc,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [31:0]          resp_inst,
   output logic [CPU_WIDTH-1:0] resp_pc,
   output logic                 resp_err,
   input  logic                 prog_wen,
   input  logic [CPU_WIDTH-1:0] prog_addr,
   input  logic [31:0]          prog_wdata
);

   localparam int                   AW       = $clog2(DEPTH);
   localparam logic [CPU_WIDTH-3:0] DEPTH_W  = (CPU_WIDTH-2)'(DEPTH);
   localparam logic [CNT_W-1:0]     CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CPU_WIDTH-1:0]   pc_p0;
   logic                   err_p1;
   logic [31:0]            rd_data_p1;
   logic [CPU_WIDTH-1:0]   rd_pc;
   logic [CPU_WIDTH-3:0]   rd_off, wr_off;
   logic                   rd_ok, wr_ok, rd_en, accept;

   assign accept = req_valid && req_ready;

   // With LATENCY=1 the read is issued at the accept edge, before pc_p0 is loaded.
   assign rd_pc  = (state_q == IDLE) ? req_pc : pc_p0;
   assign rd_off = word_off(rd_pc[CPU_WIDTH-1:2], BASE_ADDR[CPU_WIDTH-1:2]);
`ifdef IMEM_MISALIGN_CHK_EN
   assign rd_ok  = (rd_pc >= BASE_ADDR) && (rd_off < DEPTH_W) && (rd_pc[1:0] == 2'b00);
`else
   assign rd_ok  = (rd_pc >= BASE_ADDR) && (rd_off < DEPTH_W);
`endif

   assign wr_off = word_off(prog_addr[CPU_WIDTH-1:2], BASE_ADDR[CPU_WIDTH-1:2]);
   assign wr_ok  = prog_wen && (prog_addr >= BASE_ADDR) && (wr_off < DEPTH_W);

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rd_en     = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
                  rd_en   = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               rd_en   = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                                cnt_q <= '0;
      else if (accept)                           cnt_q <= CNT_INIT;
      else if (state_q == WAIT && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
   end

   // Stage p0: request address captured at accept
   always_ff @(posedge clk) begin
      if (accept) pc_p0 <= req_pc;
   end

   // Stage p1: fault flag and array word captured on entry to RESP
   always_ff @(posedge clk) begin
      if (rd_en) err_p1 <= !rd_ok;
   end

   imem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .wen   (wr_ok),
      .waddr (wr_off[AW-1:0]),
      .wdata (prog_wdata),
      .ren   (rd_en),
      .raddr (rd_off[AW-1:0]),
      .rdata (rd_data_p1)
   );

   assign resp_valid = (state_q == RESP);
   assign resp_inst  = !resp_valid ? 32'h0 : (err_p1 ? NOP_INST : rd_data_p1);
   assign resp_pc    = resp_valid ? pc_p0 : '0;
   assign resp_err   = resp_valid && err_p1;

endmodule

// File: tb/tb_imem_resp.sv
// Scoreboard bench for imem_resp: one LATENCY=2 instance and one LATENCY=1
// instance sharing clock, reset and loader port.
module tb_imem_resp;

   localparam int LAT0 = 2;
   localparam int LAT1 = 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        prog_wen;
   logic [31:0] prog_addr, prog_wdata;

   logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
   logic [31:0] req_pc, resp_inst, resp_pc;
   logic        req_valid_1, req_ready_1, resp_valid_1, resp_ready_1, resp_err_1;
   logic [31:0] req_pc_1, resp_inst_1, resp_pc_1;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   tests  = 0;
   int   failed = 0;
   int   cyc    = 0;
   logic pv0    = 1'b0;
   logic pv1    = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   imem_resp #(.DEPTH(1024), .LATENCY(LAT0), .BASE_ADDR(32'h8000_0000)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_pc(req_pc), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_inst(resp_inst), .resp_pc(resp_pc), .resp_err(resp_err),
      .prog_wen(prog_wen), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
   );

   imem_resp #(.DEPTH(1024), .LATENCY(LAT1), .BASE_ADDR(32'h8000_0000)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_1), .req_ready(req_ready_1),
      .req_pc(req_pc_1), .resp_valid(resp_valid_1), .resp_ready(resp_ready_1),
      .resp_inst(resp_inst_1), .resp_pc(resp_pc_1), .resp_err(resp_err_1),
      .prog_wen(prog_wen), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Monitors: each new response is matched against the oldest expectation.
   always @(negedge clk) begin : mon0
      exp_t e;
      if (resp_valid && !pv0) begin
         if (q0.size() == 0) begin
            tests++; failed++;
            $display("FAIL d0_unexpected_resp: got pc %h, required no response", resp_pc);
         end else begin
            e = q0.pop_front();
            check("d0_inst", resp_inst, e.inst);
            check("d0_pc", resp_pc, e.pc);
            check("d0_err", 32'(resp_err), 32'(e.err));
            check("d0_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      pv0 = resp_valid;
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (resp_valid_1 && !pv1) begin
         if (q1.size() == 0) begin
            tests++; failed++;
            $display("FAIL d1_unexpected_resp: got pc %h, required no response", resp_pc_1);
         end else begin
            e = q1.pop_front();
            check("d1_inst", resp_inst_1, e.inst);
            check("d1_pc", resp_pc_1, e.pc);
            check("d1_err", 32'(resp_err_1), 32'(e.err));
            check("d1_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      pv1 = resp_valid_1;
   end

   task automatic pr(input logic [31:0] a, input logic [31:0] d);
      prog_addr  = a;
      prog_wdata = d;
      prog_wen   = 1'b1;
      @(posedge clk); #1;
      prog_wen   = 1'b0;
   endtask

   task automatic issue0(input logic [31:0] pc, input logic [31:0] inst,
                         input logic err, input bit push);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("d0_req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_pc    = pc;
      @(posedge clk); #1;
      if (push) q0.push_back('{inst, pc, err, cyc + LAT0 - 1});
      req_valid = 1'b0;
   endtask

   task automatic wait_idle0();
      int n = 0;
      @(negedge clk);
      while (!(req_ready && q0.size() == 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("d0_idle_timeout", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] pcs  [4];
      logic [31:0] insts[4];
      logic        errs [4];
      int          c0;
      int          n;

      rst_n = 1'b0; prog_wen = 1'b0; prog_addr = '0; prog_wdata = '0;
      req_valid = 1'b0; req_pc = '0; resp_ready = 1'b1;
      req_valid_1 = 1'b0; req_pc_1 = '0; resp_ready_1 = 1'b1;
      c0 = 0;

      repeat (3) @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_inst", resp_inst, 32'd0);
      check("rst_resp_pc", resp_pc, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_req_ready_1", 32'(req_ready_1), 32'd1);

      pr(32'h8000_0000, 32'h0010_0093);
      pr(32'h8000_0004, 32'h0020_0113);
      pr(32'h8000_0009, 32'h1234_5678);
      pr(32'h8000_0FFC, 32'hDEAD_BEEF);
      pr(32'h8000_1000, 32'hFFFF_FFFF);
      pr(32'h7FFF_FFFC, 32'hEEEE_EEEE);

      issue0(32'h8000_0000, 32'h0010_0093, 1'b0, 1'b1);
      issue0(32'h8000_0004, 32'h0020_0113, 1'b0, 1'b1);
      issue0(32'h8000_0008, 32'h1234_5678, 1'b0, 1'b1);
      issue0(32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0, 1'b1);
      issue0(32'h7FFF_FFFC, NOP, 1'b1, 1'b1);
      issue0(32'h8000_1000, NOP, 1'b1, 1'b1);
`ifdef IMEM_MISALIGN_CHK_EN
      issue0(32'h8000_0002, NOP, 1'b1, 1'b1);
`else
      issue0(32'h8000_0002, 32'h0010_0093, 1'b0, 1'b1);
`endif

      // Back-pressure: response held for five cycles.
      wait_idle0();
      resp_ready = 1'b0;
      issue0(32'h8000_0004, 32'h0020_0113, 1'b0, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 10);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 32'(resp_valid), 32'd1);
         check("stall_inst", resp_inst, 32'h0020_0113);
         check("stall_pc", resp_pc, 32'h8000_0004);
         check("stall_req_ready", 32'(req_ready), 32'd0);
         if (i < 4) @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      check("release_req_ready", 32'(req_ready), 32'd1);
      check("release_valid", 32'(resp_valid), 32'd0);
      check("release_inst", resp_inst, 32'd0);
      check("release_pc", resp_pc, 32'd0);

      // Loader write lands on the same edge as the read: old word returned.
      wait_idle0();
      issue0(32'h8000_0004, 32'h0020_0113, 1'b0, 1'b1);
      pr(32'h8000_0004, 32'hAAAA_0001);
      wait_idle0();
      issue0(32'h8000_0004, 32'hAAAA_0001, 1'b0, 1'b1);
      wait_idle0();

      // Reset while waiting: the fetch must vanish.
      issue0(32'h8000_0000, 32'h0010_0093, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("wait_rst_req_ready", 32'(req_ready), 32'd1);
      check("wait_rst_valid", 32'(resp_valid), 32'd0);
      repeat (6) @(negedge clk);

      // LATENCY=1 instance with req_valid held: one response every two cycles.
      pcs[0] = 32'h8000_0000; insts[0] = 32'h0010_0093; errs[0] = 1'b0;
      pcs[1] = 32'h8000_0004; insts[1] = 32'hAAAA_0001; errs[1] = 1'b0;
      pcs[2] = 32'h8000_0FFC; insts[2] = 32'hDEAD_BEEF; errs[2] = 1'b0;
      pcs[3] = 32'h8000_1000; insts[3] = NOP;           errs[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 0) @(negedge clk);
         else        repeat (2) @(negedge clk);
         req_pc_1    = pcs[i];
         req_valid_1 = 1'b1;
         @(posedge clk); #1;
         if (i == 0) c0 = cyc;
         q1.push_back('{insts[i], pcs[i], errs[i], c0 + 2 * i + LAT1 - 1});
      end
      @(negedge clk);
      req_valid_1 = 1'b0;

      repeat (8) @(negedge clk);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
- REQ-001 Parameter DEPTH, default 1024: instruction words held; power of two.
- REQ-002 Parameter LATENCY, default 2: cycles from request accept to resp_valid; legal range 1..15.
- REQ-003 Parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
- REQ-004 clk  in  1  single clock; all logic on rising edge.
- REQ-005 rst_n  in  1  reset, synchronous, active-low.
- REQ-006 req_valid  in  1  fetch request from core.
- REQ-007 req_ready  out  1  responder can accept a request.
- REQ-008 req_pc  in  CPU_WIDTH  fetch byte address.
- REQ-009 resp_valid  out  1  instruction available.
- REQ-010 resp_ready  in  1  core consumes response.
- REQ-011 resp_inst  out  32  fetched instruction.
- REQ-012 resp_pc  out  CPU_WIDTH  address of the returned instruction.
- REQ-013 resp_err  out  1  access fault for this response.
- REQ-014 prog_wen / prog_addr (CPU_WIDTH) / prog_wdata (32)  in  loader write port; word write at prog_addr.

Function
- REQ-015 States: IDLE, WAIT, RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
- REQ-016 Accept = req_valid&&req_ready at an edge; latch req_pc; LATENCY=1 -> RESP, else -> WAIT with counter=LATENCY-2.
- REQ-017 WAIT: counter decrements each cycle; at 0 -> RESP; resp_valid rises exactly LATENCY cycles after accept edge.
- REQ-018 RESP: resp_inst/resp_pc/resp_err stable while resp_valid&&!resp_ready; on resp_ready -> IDLE; req_ready high next cycle (max throughput one fetch per LATENCY+1 cycles).
- REQ-019 Word index = (pc-BASE_ADDR)>>2; pc below BASE_ADDR or index>=DEPTH -> resp_err=1, resp_inst=32'h0000_0013 (NOP).
- REQ-020 Array read registered on entry to RESP; prog write to same word in that cycle -> response carries old data.
- REQ-021 prog_wen writes in any state; out-of-range prog_addr ignored; prog_addr[1:0] ignored.
- REQ-022 resp_inst/resp_pc/resp_err are 0 outside RESP except as in REQ-019.

Reset
- REQ-023 rst_n low at edge: state IDLE, counter 0, req_ready=1 after release, resp_valid=0, resp_inst=0, resp_pc=0, resp_err=0.
- REQ-024 Reset in WAIT or RESP drops outstanding fetch; no response issued.
- REQ-025 Array contents not reset.

Configuration
- REQ-026 Macro IMEM_MISALIGN_CHK_EN defined: req_pc[1:0]!=0 -> resp_err=1, resp_inst=NOP, timing unchanged.
- REQ-027 Macro undefined: req_pc[1:0] ignored, word at truncated address returned, resp_err only from range check.

Structure
- REQ-028 State encoding, NOP constant, LATENCY counter width live in the shared defines header alongside CPU_WIDTH.
- REQ-029 Sub-module imem_array: DEPTH x 32 storage, one write port, one registered read port.

Verification
- REQ-030 Program word 0 = 32'h0010_0093, req_pc=32'h8000_0000 accepted cycle 0, LATENCY=2 -> resp_valid cycle 2, resp_inst=32'h0010_0093, resp_err=0.
- REQ-031 resp_ready held low 5 cycles in RESP -> outputs stable, req_ready=0 throughout; release -> req_ready=1 next cycle.
- REQ-032 req_pc=32'h7FFF_FFFC and 32'h8000_1000 (DEPTH=1024) -> resp_err=1, resp_inst=32'h0000_0013.
- REQ-033 req_pc=32'h8000_0002: with IMEM_MISALIGN_CHK_EN -> resp_err=1; without -> word 0, resp_err=0.
- REQ-034 rst_n low during WAIT -> resp_valid never rises for that fetch; req_ready=1 first cycle after release.
- REQ-035 LATENCY=1, back-to-back requests with resp_ready=1 -> one response every 2 cycles, resp_pc matches request order.
